softmax_row_bridge: RTL and testbench
=====================================

// Module: softmax_row_bridge
// PURPOSE
//  Host-side bridge for the softmax engine's 64-bit beat interface. Accepts a full row
//  (64 x FP16 = 1024 bits), streams it to the engine as 16 beats, and reassembles the
//  16 result beats into a 1024-bit result row for the consumer.
//  Caps rows in flight so the engine's internal pipeline is never over-issued.
// PARAMETERS
//  BEATS            16  beats per row (64 FP16 / 4 lanes)
//  LANE_W           64  beat width in bits (4 x FP16); ROW_W = BEATS*LANE_W
//  MAX_OUTSTANDING  2   max rows accepted but not yet returned (1..7)
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      async active-low reset
//  row_in         in   ROW_W  input row; FP16 element i at [16i+:16]
//  row_in_valid   in   1      input row valid
//  row_in_ready   out  1      bridge accepts row this cycle
//  sm_x_in        out  LANE_W beat to engine
//  sm_x_in_valid  out  1      beat valid to engine
//  sm_ready       in   1      engine ready for beat
//  sm_data        in   LANE_W result beat from engine
//  sm_valid       in   1      result beat valid
//  sm_next_ready  out  1      bridge ready for result beat
//  res_row        out  ROW_W  reassembled result row
//  res_valid      out  1      result row valid
//  res_ready      in   1      consumer ready
//  outstanding    out  3      rows in flight
//  err_unexpected out  1      sticky: result beat arrived with outstanding==0
// BEHAVIOUR
//  Handshakes: transfer iff valid&&ready on a rising edge. Once a valid is asserted, it and
//  its data stay stable until the transfer.
//  Reset (async, rst_n=0): all outputs 0; tx/rx FSMs idle/collect; counters 0; buffers 0.
//  TX FSM, states TX_IDLE and TX_SEND:
//   - TX_IDLE: row_in_ready = (outstanding < MAX_OUTSTANDING). On accept: latch row into
//     tx_buf, tx_cnt=0, outstanding increments, go to TX_SEND.
//   - TX_SEND: row_in_ready=0, sm_x_in_valid=1, sm_x_in = tx_buf[tx_cnt*LANE_W +: LANE_W].
//     Beat 0 is the LSBs. On each sm_ready handshake, tx_cnt++.
//   - On the handshake with tx_cnt==BEATS-1: go to TX_IDLE, sm_x_in_valid=0 next cycle.
//   - Latency: row accepted in cycle N; beat 0 is presented in N+1. With sm_ready held
//     high, the last beat goes in N+16 and row_in_ready may reassert in N+17.
//  RX FSM, states RX_COLLECT and RX_HOLD:
//   - RX_COLLECT: sm_next_ready=1. Each handshake writes sm_data into
//     rx_buf[rx_cnt*LANE_W +: LANE_W] and increments rx_cnt.
//   - On the handshake with rx_cnt==BEATS-1: go to RX_HOLD; res_valid=1 next cycle.
//   - RX_HOLD: sm_next_ready=0, res_row=rx_buf held stable. On res_ready: res_valid=0,
//     rx_cnt=0, outstanding decrements, go to RX_COLLECT.
//  outstanding: +1 on row accept, -1 on result-row handshake. Both in the same cycle ->
//   unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
//  Unexpected beat (sm_valid && sm_next_ready && outstanding==0): beat is discarded,
//   rx_cnt unchanged, err_unexpected set and held until reset.
//  TX and RX run independently: the engine may return row k while row k+1 streams in.
//  Reset mid-row: partial beats are dropped and the FSMs restart clean. The engine must
//   be reset in the same event.
//  No arithmetic on the payload: the bridge is bit-exact pass-through of FP16 words.
// TESTING
//  1 Reset: assert rst_n=0 mid-TX_SEND (tx_cnt=7) -> all outputs 0 at once, outstanding=0,
//    row_in_ready=1 one cycle after release.
//  2 Single row, elem i = 16'h3C00+i, sm_ready=1 -> beat0 = {16'h3C03,16'h3C02,16'h3C01,16'h3C00}
//    in cycle N+1, beat15 in N+16, row_in_ready=1 in N+17.
//  3 Loopback model returning each beat +8 cycles later, res_ready=1 -> res_row == row_in
//    bit-exact, res_valid high for 1 cycle, outstanding back to 0.
//  4 MAX_OUTSTANDING=2, res_ready=0 and 3 rows offered -> third row stalls
//    (row_in_ready=0, outstanding=2). One res_ready pulse -> third row accepted.
//  5 sm_ready toggling 1010... -> 16 beats in 32 cycles, in order, sm_x_in stable while stalled.
//  6 sm_valid=1 at outstanding==0 -> err_unexpected=1 next cycle and sticky, rx_cnt stays 0.
//    Same-cycle accept + return -> outstanding unchanged.

Source files
------------

// File: rtl/softmax_row_bridge.sv
// softmax_row_bridge: splits 1024-bit rows into 64-bit beats for the softmax engine and
// reassembles the returned beats into result rows, capping rows in flight.
//   clk, rst_n                      clock (rising edge), async active-low reset
//   row_in/_valid/_ready            full input row from host (FP16 element i at [16i+:16])
//   sm_x_in/_valid, sm_ready        beat stream to engine, beat 0 = row LSBs
//   sm_data, sm_valid/sm_next_ready result beat stream from engine
//   res_row/_valid, res_ready       reassembled result row to consumer
//   outstanding                     rows accepted but not yet returned
//   err_unexpected                  sticky: result beat seen with nothing in flight
module softmax_row_bridge #(
    parameter int BEATS = 16,
    parameter int LANE_W = 64,
    parameter int MAX_OUTSTANDING = 2,
    localparam int ROW_W = BEATS * LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROW_W-1:0]  row_in,
    input  logic              row_in_valid,
    output logic              row_in_ready,
    output logic [LANE_W-1:0] sm_x_in,
    output logic              sm_x_in_valid,
    input  logic              sm_ready,
    input  logic [LANE_W-1:0] sm_data,
    input  logic              sm_valid,
    output logic              sm_next_ready,
    output logic [ROW_W-1:0]  res_row,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2:0]        outstanding,
    output logic              err_unexpected
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic [ROW_W-1:0] tx_buf, rx_buf;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic live, accept, tx_hs, rx_hs, rx_take, res_hs, unexpected;

    always_comb begin
        // live holds both ready outputs low during reset and for the first cycle after release
        row_in_ready  = live && tx_state == TX_IDLE && outstanding < 3'(MAX_OUTSTANDING);
        sm_x_in_valid = tx_state == TX_SEND;
        sm_x_in       = tx_buf[int'(tx_cnt) * LANE_W +: LANE_W];
        sm_next_ready = live && rx_state == RX_COLLECT;
        res_valid     = rx_state == RX_HOLD;
        res_row       = rx_buf;
        accept        = row_in_valid && row_in_ready;
        tx_hs         = sm_x_in_valid && sm_ready;
        rx_hs         = sm_valid && sm_next_ready;
        unexpected    = rx_hs && outstanding == 3'd0;
        rx_take       = rx_hs && !unexpected;
        res_hs        = res_valid && res_ready;
        tx_next = (tx_state == TX_IDLE) ? (accept ? TX_SEND : TX_IDLE)
                                        : ((tx_hs && tx_cnt == LAST) ? TX_IDLE : TX_SEND);
        rx_next = (rx_state == RX_COLLECT) ? ((rx_take && rx_cnt == LAST) ? RX_HOLD : RX_COLLECT)
                                           : (res_hs ? RX_COLLECT : RX_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state       <= TX_IDLE;
            rx_state       <= RX_COLLECT;
            tx_buf         <= '0;
            rx_buf         <= '0;
            tx_cnt         <= '0;
            rx_cnt         <= '0;
            live           <= 1'b0;
            outstanding    <= 3'd0;
            err_unexpected <= 1'b0;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
            live     <= 1'b1;
            if (accept) begin
                tx_buf <= row_in;
                tx_cnt <= '0;
            end else if (tx_hs) begin
                tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + CW'(1);
            end
            if (rx_take) begin
                rx_buf[int'(rx_cnt) * LANE_W +: LANE_W] <= sm_data;
                rx_cnt <= (rx_cnt == LAST) ? '0 : rx_cnt + CW'(1);
            end else if (res_hs) begin
                rx_cnt <= '0;
            end
            // simultaneous accept and result handshake leave the count unchanged
            if (accept && !res_hs)
                outstanding <= outstanding + 3'd1;
            else if (res_hs && !accept)
                outstanding <= outstanding - 3'd1;
            if (unexpected)
                err_unexpected <= 1'b1;
        end
    end
endmodule

// File: tb/tb_softmax_row_bridge.sv
// tb_softmax_row_bridge: self-checking bench with loopback engine model and row scoreboard
module tb_softmax_row_bridge;
    localparam int BEATS = 16;
    localparam int LANE_W = 64;
    localparam int ROW_W = BEATS * LANE_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [ROW_W-1:0] row_in = '0;
    logic row_in_valid = 1'b0;
    logic row_in_ready;
    logic [LANE_W-1:0] sm_x_in;
    logic sm_x_in_valid;
    logic sm_ready = 1'b0;
    logic [LANE_W-1:0] sm_data = '0;
    logic sm_valid = 1'b0;
    logic sm_next_ready;
    logic [ROW_W-1:0] res_row;
    logic res_valid;
    logic res_ready = 1'b0;
    logic [2:0] outstanding;
    logic err_unexpected;

    always #5 clk = ~clk;

    softmax_row_bridge #(.BEATS(BEATS), .LANE_W(LANE_W), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .row_in(row_in), .row_in_valid(row_in_valid), .row_in_ready(row_in_ready),
        .sm_x_in(sm_x_in), .sm_x_in_valid(sm_x_in_valid), .sm_ready(sm_ready),
        .sm_data(sm_data), .sm_valid(sm_valid), .sm_next_ready(sm_next_ready),
        .res_row(res_row), .res_valid(res_valid), .res_ready(res_ready),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        logic [63:0] beat0;
        logic [63:0] beat15;
    } vec_t;

    typedef struct {
        int t;
        logic [63:0] d;
    } ebeat_t;

    ebeat_t eng_q[$];
    logic [ROW_W-1:0] exp_tx[$];
    logic [ROW_W-1:0] exp_res[$];
    int errors = 0, checks = 0, cyc_n = 0, tx_idx = 0;
    int tx_hs_cnt = 0, acc_cnt = 0, res_cnt = 0;
    bit loop_en = 0, stall_pend = 0;
    logic [63:0] stall_val = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc_n);
        end
    endtask

    task automatic check_row(input string name, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        int idx;
        idx = -1;
        for (int i = BEATS - 1; i >= 0; i--)
            if (got[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
        checks++;
        if (idx >= 0) begin
            errors++;
            $display("FAIL %s: lane %0d got %h expected %h (cycle %0d)", name, idx,
                     got[idx*64 +: 64], exp[idx*64 +: 64], cyc_n);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc_n);
    endtask

    function automatic logic [ROW_W-1:0] mk_row(input logic [15:0] base, input logic [15:0] step);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < 64; i++) r[16*i +: 16] = base + step * 16'(i);
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rnd_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: engine model drive, scoreboard observation, then the edge.
    task automatic cyc();
        logic [ROW_W-1:0] r;
        ebeat_t e;
        if (loop_en) begin
            sm_valid = eng_q.size() > 0 && eng_q[0].t <= cyc_n;
            sm_data = sm_valid ? eng_q[0].d : '0;
        end
        #1;
        if (stall_pend) check("tx_stall_hold", sm_x_in, stall_val);
        stall_pend = sm_x_in_valid && !sm_ready;
        stall_val = sm_x_in;
        if (row_in_valid && row_in_ready) begin
            exp_tx.push_back(row_in);
            exp_res.push_back(row_in);
            acc_cnt++;
        end
        if (sm_x_in_valid && sm_ready) begin
            tx_hs_cnt++;
            if (exp_tx.size() == 0) fail_now("tx_beat_unexpected");
            else begin
                r = exp_tx[0];
                check("tx_beat", sm_x_in, r[tx_idx*64 +: 64]);
                tx_idx++;
                if (tx_idx == BEATS) begin
                    tx_idx = 0;
                    void'(exp_tx.pop_front());
                end
            end
            if (loop_en) begin
                e.t = cyc_n + 8;
                e.d = sm_x_in;
                eng_q.push_back(e);
            end
        end
        if (sm_valid && sm_next_ready && loop_en && eng_q.size() > 0) void'(eng_q.pop_front());
        if (res_valid && res_ready) begin
            res_cnt++;
            if (exp_res.size() == 0) fail_now("res_row_unexpected");
            else check_row("res_row", res_row, exp_res.pop_front());
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic send_row(input logic [ROW_W-1:0] row, input int max);
        int start, n;
        start = acc_cnt;
        n = 0;
        row_in = row;
        row_in_valid = 1'b1;
        while (acc_cnt == start && n < max) begin
            cyc();
            n++;
        end
        row_in_valid = 1'b0;
        if (acc_cnt == start) fail_now("row_accept_timeout");
    endtask

    task automatic wait_res(input int max);
        int start, n;
        start = res_cnt;
        n = 0;
        while (res_cnt == start && n < max) begin
            cyc();
            n++;
        end
        if (res_cnt == start) fail_now("result_timeout");
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((outstanding != 3'd0 || exp_res.size() != 0) && n < max) begin
            cyc();
            n++;
        end
        check("idle_outstanding", 64'(outstanding), 64'd0);
        check("idle_scoreboard", 64'(exp_res.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        logic [ROW_W-1:0] ra, rb, rc;
        int a0, h0, n;
        vecs[0] = '{16'h3C00, 16'h0001, 64'h3C03_3C02_3C01_3C00, 64'h3C3F_3C3E_3C3D_3C3C};
        vecs[1] = '{16'h0000, 16'h0000, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
        vecs[2] = '{16'hFFFF, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{16'h8000, 16'h0100, 64'h8300_8200_8100_8000, 64'hBF00_BE00_BD00_BC00};
        vecs[4] = '{16'h7BFF, 16'hFFFF, 64'h7BFC_7BFD_7BFE_7BFF, 64'h7BC0_7BC1_7BC2_7BC3};

        repeat (3) @(posedge clk);
        #1;
        check("rst_row_in_ready", 64'(row_in_ready), 64'd0);
        check("rst_sm_next_ready", 64'(sm_next_ready), 64'd0);
        check("rst_sm_x_in_valid", 64'(sm_x_in_valid), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        rst_n = 1'b1;
        check("release_row_in_ready", 64'(row_in_ready), 64'd0);
        cyc();
        check("post_rst_row_in_ready", 64'(row_in_ready), 64'd1);
        check("post_rst_sm_next_ready", 64'(sm_next_ready), 64'd1);

        // single-row latency and loopback integrity, table driven
        loop_en = 1;
        sm_ready = 1'b1;
        res_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            send_row(mk_row(vecs[v].base, vecs[v].step), 50);
            check("n1_sm_x_in_valid", 64'(sm_x_in_valid), 64'd1);
            check("n1_beat0", sm_x_in, vecs[v].beat0);
            repeat (15) cyc();
            check("n16_beat15", sm_x_in, vecs[v].beat15);
            check("n16_row_in_ready", 64'(row_in_ready), 64'd0);
            cyc();
            check("n17_row_in_ready", 64'(row_in_ready), 64'd1);
            check("n17_sm_x_in_valid", 64'(sm_x_in_valid), 64'd0);
            wait_res(100);
            check("res_valid_one_cycle", 64'(res_valid), 64'd0);
            check("loop_outstanding", 64'(outstanding), 64'd0);
        end

        // sm_ready toggling: 16 beats in 32 cycles, data held while stalled
        sm_ready = 1'b0;
        send_row(rnd_row(), 50);
        h0 = tx_hs_cnt;
        for (int k = 0; k < 32; k++) begin
            sm_ready = (k % 2) == 1;
            cyc();
        end
        check("toggle_beats", 64'(tx_hs_cnt - h0), 64'd16);
        check("toggle_done", 64'(sm_x_in_valid), 64'd0);
        sm_ready = 1'b1;
        wait_res(100);
        wait_idle(200);

        // outstanding cap: third row stalls until one result is consumed
        res_ready = 1'b0;
        ra = rnd_row();
        rb = rnd_row();
        rc = rnd_row();
        send_row(ra, 50);
        send_row(rb, 50);
        a0 = acc_cnt;
        row_in = rc;
        row_in_valid = 1'b1;
        repeat (40) cyc();
        check("cap_no_accept", 64'(acc_cnt - a0), 64'd0);
        check("cap_row_in_ready", 64'(row_in_ready), 64'd0);
        check("cap_outstanding", 64'(outstanding), 64'd2);
        check("cap_res_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        send_row(rc, 50);
        check("cap_after_accept", 64'(outstanding), 64'd2);
        res_ready = 1'b1;
        wait_idle(300);

        // unexpected beat: sticky error, beat discarded
        loop_en = 0;
        check("err_before", 64'(err_unexpected), 64'd0);
        sm_data = 64'hDEAD_BEEF_0000_1111;
        sm_valid = 1'b1;
        cyc();
        sm_valid = 1'b0;
        sm_data = '0;
        check("err_set", 64'(err_unexpected), 64'd1);
        check("err_outstanding", 64'(outstanding), 64'd0);
        repeat (3) cyc();
        check("err_sticky", 64'(err_unexpected), 64'd1);
        loop_en = 1;
        send_row(rnd_row(), 50);
        wait_res(100);
        check("err_still_sticky", 64'(err_unexpected), 64'd1);

        // same-cycle accept and result handshake
        res_ready = 1'b0;
        send_row(rnd_row(), 50);
        n = 0;
        while (!res_valid && n < 100) begin
            cyc();
            n++;
        end
        check("same_res_valid", 64'(res_valid), 64'd1);
        check("same_row_in_ready", 64'(row_in_ready), 64'd1);
        check("same_before", 64'(outstanding), 64'd1);
        row_in = rnd_row();
        row_in_valid = 1'b1;
        res_ready = 1'b1;
        cyc();
        row_in_valid = 1'b0;
        check("same_after", 64'(outstanding), 64'd1);
        wait_idle(200);

        // reset in the middle of a row (tx_cnt = 7)
        ra = mk_row(16'h1000, 16'h0001);
        send_row(ra, 50);
        repeat (7) cyc();
        check("mid_beat7", sm_x_in, ra[7*64 +: 64]);
        rst_n = 1'b0;
        #1;
        check("mid_rst_row_in_ready", 64'(row_in_ready), 64'd0);
        check("mid_rst_sm_x_in_valid", 64'(sm_x_in_valid), 64'd0);
        check("mid_rst_sm_x_in", sm_x_in, 64'd0);
        check("mid_rst_sm_next_ready", 64'(sm_next_ready), 64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check_row("mid_rst_res_row", res_row, '0);
        check("mid_rst_outstanding", 64'(outstanding), 64'd0);
        check("mid_rst_err", 64'(err_unexpected), 64'd0);
        eng_q.delete();
        exp_tx.delete();
        exp_res.delete();
        tx_idx = 0;
        stall_pend = 0;
        sm_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_release_ready", 64'(row_in_ready), 64'd0);
        cyc();
        check("mid_ready_after", 64'(row_in_ready), 64'd1);
        send_row(rnd_row(), 50);
        wait_res(100);
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
